// File: rtl/cache_wb_nway.sv
// N-way set-associative write-back cache with round-robin replacement and
// burst-based line fill / dirty-victim writeback.
module cache_wb_nway #(
  parameter int unsigned WAYS            = 2,
  parameter int unsigned LINES           = 64,
  parameter int unsigned WORDS_PER_BLOCK = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] d,
  input  logic        we,
  input  logic        rd,
  output logic [31:0] spo,
  output logic        ready,
  output logic        burst_en,
  output logic [7:0]  burst_length,
  output logic [31:0] lowmem_a,
  output logic [31:0] lowmem_d,
  output logic        lowmem_we,
  output logic        lowmem_rd,
  input  logic [31:0] lowmem_spo,
  input  logic        lowmem_ready,
  output logic        hit,
  output logic        miss
);

  localparam int unsigned OB = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned IB = $clog2(LINES);
  localparam int unsigned TB = 30 - OB - IB;
  localparam int unsigned WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [OB+1:0] ZOFF = '0;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_HIT, S_RESP, S_WB, S_LOAD
  } state_t;

  // Storage arrays
  logic [31:0]   r_data  [WAYS][LINES][WORDS_PER_BLOCK];
  logic [TB-1:0] r_tag   [WAYS][LINES];
  logic          r_valid [WAYS][LINES];
  logic          r_dirty [WAYS][LINES];
  logic [WW-1:0] r_rr    [LINES];

  state_t        r_state, w_state_n;
  logic [IB-1:0] r_init_cnt;
  logic [OB-1:0] r_beat;
  logic [WW-1:0] r_way;
  logic          r_evict;
  logic [TB-1:0] r_req_tag;
  logic [IB-1:0] r_idx;
  logic [OB-1:0] r_off;
  logic          r_is_wr;

  logic [31:0]   r_spo, r_lowmem_a, r_lowmem_d;
  logic          r_ready, r_hit, r_miss, r_burst_en, r_lowmem_we, r_lowmem_rd;

  logic [OB-1:0] w_off;
  logic [IB-1:0] w_idx;
  logic [TB-1:0] w_tag;
  logic          w_req;
  logic          w_hit, w_has_inv, w_vic_dirty;
  logic [WW-1:0] w_hit_way, w_inv_way, w_victim;
  logic          w_beat_fire, w_last_beat;
  logic          w_unused_lsb;

  assign w_off        = a[OB+1:2];
  assign w_idx        = a[OB+IB+1:OB+2];
  assign w_tag        = a[31:OB+IB+2];
  assign w_req        = we | rd;
  assign w_unused_lsb = ^a[1:0];
  assign w_beat_fire  = r_burst_en & lowmem_ready;
  assign w_last_beat  = (r_beat == OB'(WORDS_PER_BLOCK - 1));

  // Tag lookup across all ways and victim selection for the requested set
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (r_valid[WW'(i)][w_idx] && (r_tag[WW'(i)][w_idx] == w_tag) && !w_hit) begin
        w_hit     = 1'b1;
        w_hit_way = WW'(i);
      end
      if (!r_valid[WW'(i)][w_idx] && !w_has_inv) begin
        w_has_inv = 1'b1;
        w_inv_way = WW'(i);
      end
    end
    w_victim    = w_has_inv ? w_inv_way : r_rr[w_idx];
    w_vic_dirty = r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_INIT;
    else     r_state <= w_state_n;
  end

  // Next-state logic
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_INIT: if (r_init_cnt == IB'(LINES - 1)) w_state_n = S_IDLE;
      S_IDLE: if (w_req) w_state_n = w_hit ? S_HIT : (w_vic_dirty ? S_WB : S_LOAD);
      S_HIT:  w_state_n = S_RESP;
      S_RESP: w_state_n = S_IDLE;
      S_WB:   if (w_beat_fire && w_last_beat) w_state_n = S_LOAD;
      S_LOAD: if (w_beat_fire && w_last_beat) w_state_n = S_HIT;
      default: w_state_n = S_INIT;
    endcase
  end

  // Counters and the latched request context
  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_cnt <= '0;
      r_beat     <= '0;
      r_way      <= '0;
      r_evict    <= 1'b0;
      r_req_tag  <= '0;
      r_idx      <= '0;
      r_off      <= '0;
      r_is_wr    <= 1'b0;
    end else begin
      if (r_state == S_INIT) r_init_cnt <= r_init_cnt + IB'(1);
      if (w_beat_fire)       r_beat     <= r_beat + OB'(1);
      if (r_state == S_IDLE && w_req) begin
        r_way     <= w_hit ? w_hit_way : w_victim;
        r_evict   <= !w_has_inv;
        r_req_tag <= w_tag;
        r_idx     <= w_idx;
        r_off     <= w_off;
        r_is_wr   <= we;
      end
    end
  end

  // Tag/valid/dirty and replacement-pointer maintenance
  always_ff @(posedge clk) begin
    if (!rst) begin
      case (r_state)
        S_INIT: begin
          for (int unsigned i = 0; i < WAYS; i++) begin
            r_valid[WW'(i)][r_init_cnt] <= 1'b0;
            r_dirty[WW'(i)][r_init_cnt] <= 1'b0;
          end
          if (r_init_cnt == IB'(LINES - 1)) begin
            for (int unsigned l = 0; l < LINES; l++) r_rr[IB'(l)] <= '0;
          end
        end
        S_HIT: if (r_is_wr) r_dirty[r_way][r_idx] <= 1'b1;
        S_WB:  if (w_beat_fire && w_last_beat) r_dirty[r_way][r_idx] <= 1'b0;
        S_LOAD: begin
          if (w_beat_fire && w_last_beat) begin
            r_tag[r_way][r_idx]   <= r_req_tag;
            r_valid[r_way][r_idx] <= 1'b1;
            r_dirty[r_way][r_idx] <= 1'b0;
            if (r_evict) begin
              r_rr[r_idx] <= (r_rr[r_idx] == WW'(WAYS - 1)) ? '0 : r_rr[r_idx] + WW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Data array: fill beats and write hits
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && w_beat_fire) begin
      r_data[r_way][r_idx][r_beat] <= lowmem_spo;
    end else if (r_state == S_HIT && r_is_wr) begin
      r_data[r_way][r_idx][r_off] <= d;
    end
  end

  // Registered outputs; burst signals drop for one cycle between writeback and fill
  always_ff @(posedge clk) begin
    if (rst) begin
      r_spo       <= '0;
      r_ready     <= 1'b0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_burst_en  <= 1'b0;
      r_lowmem_a  <= '0;
      r_lowmem_d  <= '0;
      r_lowmem_we <= 1'b0;
      r_lowmem_rd <= 1'b0;
    end else begin
      r_ready     <= (w_state_n == S_RESP);
      r_hit       <= (r_state == S_IDLE) && w_req && w_hit;
      r_miss      <= (r_state == S_IDLE) && w_req && !w_hit;
      r_burst_en  <= (w_state_n == S_WB) || (w_state_n == S_LOAD && r_state != S_WB);
      r_lowmem_we <= (w_state_n == S_WB);
      r_lowmem_rd <= (w_state_n == S_LOAD) && (r_state != S_WB);
      if (r_state == S_IDLE && w_req && !w_hit) begin
        r_lowmem_a <= w_vic_dirty ? {r_tag[w_victim][w_idx], w_idx, ZOFF} : {w_tag, w_idx, ZOFF};
        r_lowmem_d <= r_data[w_victim][w_idx][0];
      end else if (r_state == S_WB && w_beat_fire) begin
        r_lowmem_d <= r_data[r_way][r_idx][r_beat + OB'(1)];
        if (w_last_beat) r_lowmem_a <= {r_req_tag, r_idx, ZOFF};
      end
      if (r_state == S_HIT && !r_is_wr) r_spo <= r_data[r_way][r_idx][r_off];
    end
  end

  assign spo          = r_spo;
  assign ready        = r_ready;
  assign hit          = r_hit;
  assign miss         = r_miss;
  assign burst_en     = r_burst_en;
  assign burst_length = 8'(WORDS_PER_BLOCK);
  assign lowmem_a     = r_lowmem_a;
  assign lowmem_d     = r_lowmem_d;
  assign lowmem_we    = r_lowmem_we;
  assign lowmem_rd    = r_lowmem_rd;

endmodule

// File: tb/tb_cache_wb_nway.sv
// Scoreboard bench for cache_wb_nway: directed requests, burst memory model,
// and a monitor that checks each completed access and each burst.
module tb_cache_wb_nway;
  localparam int unsigned WPB = 16;

  logic        clk = 1'b0;
  logic        rst, we, rd, lowmem_ready;
  logic [31:0] a, d, lowmem_spo;
  logic [31:0] spo, lowmem_a, lowmem_d;
  logic        ready, burst_en, lowmem_we, lowmem_rd, hit, miss;
  logic [7:0]  burst_length;

  always #5 clk = ~clk;

  cache_wb_nway #(.WAYS(2), .LINES(64), .WORDS_PER_BLOCK(WPB)) dut (
    .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .rd(rd),
    .spo(spo), .ready(ready), .burst_en(burst_en), .burst_length(burst_length),
    .lowmem_a(lowmem_a), .lowmem_d(lowmem_d), .lowmem_we(lowmem_we), .lowmem_rd(lowmem_rd),
    .lowmem_spo(lowmem_spo), .lowmem_ready(lowmem_ready), .hit(hit), .miss(miss)
  );

  typedef struct packed {
    logic        is_rd;
    logic [31:0] spo;
    logic [7:0]  hits;
    logic [7:0]  misses;
    logic [1:0]  lm;        // 1: ready 2 cycles after issue; 2: ready 2 cycles after last fill beat
    logic [31:0] issue_cyc;
  } rexp_t;

  typedef struct packed {
    logic                  wr;
    logic [31:0]           addr;
    logic                  abort_ok;
    logic [WPB-1:0][31:0]  wd;
  } bexp_t;

  rexp_t rq[$];
  bexp_t bq[$];
  logic [31:0] mem [int unsigned];

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int last_beat_cyc = 0;
  int mb_cnt = 0;
  bit ready_toggle = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Initial memory image: block 0x100 holds 0xA000+k, other blocks offset by base
  function automatic logic [31:0] f_init(input logic [31:0] ba);
    logic [31:0] off;
    off = {28'd0, ba[5:2]};
    return 32'hA000 + off + (((ba & 32'hFFFF_FFC0) - 32'h100) << 4);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] ba);
    if (mem.exists(ba >> 2)) return mem[ba >> 2];
    return f_init(ba);
  endfunction

  function automatic logic [WPB-1:0][31:0] blk(input logic [31:0] base);
    logic [WPB-1:0][31:0] r;
    for (int k = 0; k < WPB; k++) r[k] = f_init(base + 32'(4 * k));
    return r;
  endfunction

  // Burst memory model; writes commit only when the whole burst completes
  initial begin
    bit in_burst, stable, tog, rdy;
    logic [31:0] mb_a;
    logic mb_we, mb_rd;
    bexp_t cur;
    logic [WPB-1:0][31:0] wbuf;
    in_burst = 0; stable = 1; tog = 0; mb_a = '0; mb_we = 0; mb_rd = 0; cur = '0; wbuf = '0;
    lowmem_ready = 1'b0;
    lowmem_spo   = '0;
    forever begin
      @(negedge clk);
      if (burst_en) begin
        if (!in_burst) begin
          in_burst = 1; stable = 1; tog = 0; mb_cnt = 0;
          mb_a = lowmem_a; mb_we = lowmem_we; mb_rd = lowmem_rd;
          if (bq.size() == 0) begin
            n_chk++;
            $display("FAIL burst_unexpected: burst at %h (we=%0b) with none required", lowmem_a, lowmem_we);
            cur = '0;
            cur.abort_ok = 1'b1;
          end else begin
            cur = bq.pop_front();
            chk("burst_addr", lowmem_a, cur.addr);
            chk("burst_dir_we", 32'(lowmem_we), 32'(cur.wr));
            chk("burst_dir_rd", 32'(lowmem_rd), 32'(!cur.wr));
          end
        end
        if (lowmem_a !== mb_a || lowmem_we !== mb_we || lowmem_rd !== mb_rd) stable = 0;
        rdy = ready_toggle ? tog : 1'b1;
        tog = ~tog;
        lowmem_ready = rdy;
        lowmem_spo   = mem_rd(mb_a + 32'(4 * mb_cnt));
        if (rdy) begin
          if (mb_we) wbuf[mb_cnt] = lowmem_d;
          last_beat_cyc = cyc;
          mb_cnt++;
          if (mb_cnt == WPB) begin
            chk("burst_stable", 32'(stable), 32'd1);
            if (mb_we) begin
              for (int k = 0; k < WPB; k++) begin
                chk($sformatf("wb_word%0d", k), wbuf[k], cur.wd[k]);
                mem[(mb_a >> 2) + 32'(k)] = wbuf[k];
              end
            end
            in_burst = 0;
            mb_cnt = 0;
          end
        end
      end else begin
        lowmem_ready = 1'b0;
        if (in_burst) begin
          chk("burst_abort_allowed", 32'(cur.abort_ok), 32'd1);
          in_burst = 0;
          mb_cnt = 0;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every ready pulse
  initial begin
    int n_hit, n_miss;
    rexp_t e;
    n_hit = 0; n_miss = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        n_hit = 0; n_miss = 0;
      end else begin
        if (hit)  n_hit++;
        if (miss) n_miss++;
        if (ready) begin
          if (rq.size() == 0) begin
            n_chk++;
            $display("FAIL ready_unexpected: ready=1 with no access outstanding, required 0");
          end else begin
            e = rq.pop_front();
            if (e.is_rd) chk("spo", spo, e.spo);
            chk("hit_pulses", 32'(n_hit), 32'(e.hits));
            chk("miss_pulses", 32'(n_miss), 32'(e.misses));
            if (e.lm == 2'd1) chk("hit_latency", 32'(cyc) - e.issue_cyc, 32'd2);
            if (e.lm == 2'd2) chk("fill_to_ready", 32'(cyc - last_beat_cyc), 32'd2);
          end
          n_hit = 0; n_miss = 0;
        end
      end
    end
  end

  task automatic push_burst(input bit wr, input logic [31:0] addr, input bit abort_ok,
                            input logic [WPB-1:0][31:0] wd);
    bexp_t b;
    b.wr = wr; b.addr = addr; b.abort_ok = abort_ok; b.wd = wd;
    bq.push_back(b);
  endtask

  // Drive a request at the current negedge and push its expected response
  task automatic issue(input bit w, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] exp_spo, input int hits, input int misses, input int lm);
    rexp_t e;
    e.is_rd = !w; e.spo = exp_spo; e.hits = 8'(hits); e.misses = 8'(misses);
    e.lm = 2'(lm); e.issue_cyc = 32'(cyc);
    rq.push_back(e);
    a = addr; d = data; we = w; rd = !w;
  endtask

  task automatic wait_ready();
    bit got;
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ready) begin got = 1; break; end
    end
    if (!got) begin
      n_chk++;
      $display("FAIL ready_timeout: no ready within 400 cycles for a=%h, required a ready pulse", a);
    end
    we = 0; rd = 0;
  endtask

  task automatic req(input bit w, input logic [31:0] addr, input logic [31:0] data,
                     input logic [31:0] exp_spo, input int hits, input int misses, input int lm);
    @(negedge clk);
    issue(w, addr, data, exp_spo, hits, misses, lm);
    wait_ready();
  endtask

  task automatic check_init_quiet(input string name);
    bit quiet;
    quiet = 1;
    repeat (64) begin
      @(negedge clk);
      if (ready || burst_en || hit || miss) quiet = 0;
    end
    chk(name, 32'(quiet), 32'd1);
  endtask

  // Directed stimulus
  initial begin
    logic [WPB-1:0][31:0] wd;
    bit got;
    rst = 1; we = 0; rd = 0; a = '0; d = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_burst_en", 32'(burst_en), 32'd0);
    chk("rst_hit_miss", 32'({hit, miss}), 32'd0);
    chk("rst_lowmem_we_rd", 32'({lowmem_we, lowmem_rd}), 32'd0);
    chk("rst_lowmem_a", lowmem_a, 32'd0);
    chk("rst_spo", spo, 32'd0);
    chk("burst_length", 32'(burst_length), 32'd16);

    // Request held through INIT, then a clean miss fill
    rst = 0;
    push_burst(0, 32'h100, 0, '0);
    issue(0, 32'h100, 0, 32'hA000, 0, 1, 2);
    check_init_quiet("init_quiet");
    wait_ready();

    req(0, 32'h104, 0, 32'hA001, 1, 0, 1);
    req(1, 32'h108, 32'hDEAD, 0, 1, 0, 1);
    req(0, 32'h108, 0, 32'hDEAD, 1, 0, 1);

    // Second way of the same set, then dirty it
    push_burst(0, 32'h1100, 0, '0);
    req(0, 32'h1100, 0, 32'h1A000, 0, 1, 2);
    req(1, 32'h1104, 32'h55, 0, 1, 0, 1);

    // Pointer picks way 0 (block 0x100, dirty with 0xDEAD)
    wd = blk(32'h100); wd[2] = 32'hDEAD;
    push_burst(1, 32'h100, 0, wd);
    push_burst(0, 32'h2100, 0, '0);
    req(0, 32'h2100, 0, 32'h2A000, 0, 1, 2);
    req(0, 32'h1100, 0, 32'h1A000, 1, 0, 1);
    req(0, 32'h1104, 0, 32'h55, 1, 0, 1);

    // Pointer picks way 1 (block 0x1100, word1 = 0x55)
    wd = blk(32'h1100); wd[1] = 32'h55;
    push_burst(1, 32'h1100, 0, wd);
    push_burst(0, 32'h3100, 0, '0);
    req(0, 32'h3100, 0, 32'h3A000, 0, 1, 2);

    // Clean victims with a slow memory
    ready_toggle = 1;
    push_burst(0, 32'h4100, 0, '0);
    req(0, 32'h4100, 0, 32'h4A000, 0, 1, 2);
    req(0, 32'h4114, 0, 32'h4A005, 1, 0, 1);
    req(0, 32'h413C, 0, 32'h4A00F, 1, 0, 1);
    push_burst(0, 32'h100, 0, '0);
    req(0, 32'h108, 0, 32'hDEAD, 0, 1, 2);
    ready_toggle = 0;

    // Reset during a dirty writeback
    req(1, 32'h4104, 32'h77, 0, 1, 0, 1);
    push_burst(1, 32'h4100, 1, '0);
    @(negedge clk);
    a = 32'h5100; rd = 1;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mb_cnt >= 5) begin got = 1; break; end
    end
    chk("wb_reached_beat5", 32'(got), 32'd1);
    rst = 1; rd = 0;
    @(negedge clk);
    chk("abort_burst_en", 32'(burst_en), 32'd0);
    chk("abort_we_rd", 32'({lowmem_we, lowmem_rd}), 32'd0);
    rst = 0;
    push_burst(0, 32'h100, 0, '0);
    issue(0, 32'h100, 0, 32'hA000, 0, 1, 2);
    check_init_quiet("reinit_quiet");
    wait_ready();
    push_burst(0, 32'h4100, 0, '0);
    req(0, 32'h4104, 0, 32'h4A001, 0, 1, 2);

    repeat (4) @(negedge clk);
    chk("resp_queue_empty", 32'(rq.size()), 32'd0);
    chk("burst_queue_empty", 32'(bq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global time bound
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule
